// File: rtl/lane_frame_scheduler.sv
// lane_frame_scheduler
//
// Frame-level sequencer for the lane display datapath. For every frame it
// walks lanes 0..NUM_LANES-1, running the erase engine over each lane's bar
// at the current scroll offset and then the draw engine one line lower. It
// muxes the active engine's pixel stream onto the single VGA write port. It
// owns the scroll offset and the per-lane content codes. When the offset
// wraps, a new code enters at lane 0 and every lane code moves up one lane.
//
// Optional feature macro: LANE_SKIP_EN. When it is defined, a phase whose
// lane code is 0 skips its engine and lasts exactly one cycle.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   frame_go / frame_done       render request / one-cycle end-of-frame pulse
//   new_row                     lane code shifted into lane 0 on offset wrap
//   row_advance                 pulses with frame_done when the offset wrapped
//   eng_lane/eng_val/eng_offset lane id, code and offset shared by both engines
//   erase_go/erase_done/x/y     erase engine handshake and pixel stream
//   draw_go/draw_done/x/y/c     draw engine handshake and pixel stream
//   x_out/y_out/c_out/plot      VGA write port
//   busy                        high in every state except IDLE
module lane_frame_scheduler #(
    parameter int         NUM_LANES  = 4,
    parameter int         OFFSET_MAX = 39,
    parameter logic [2:0] DRAW_COLOR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_go,
    input  logic [2:0] new_row,
    output logic [3:0] eng_lane,
    output logic [2:0] eng_val,
    output logic [5:0] eng_offset,
    output logic       erase_go,
    input  logic       erase_done,
    input  logic [8:0] erase_x,
    input  logic [7:0] erase_y,
    output logic       draw_go,
    input  logic       draw_done,
    input  logic [8:0] draw_x,
    input  logic [7:0] draw_y,
    input  logic       draw_c,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] c_out,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       row_advance
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_ERASE_GAP, S_DRAW, S_DRAW_GAP, S_FINISH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] lane_q, lane_d;
    logic [5:0] offset_q, offset_d;
    logic [2:0] lane_reg_q [0:NUM_LANES-1];
    logic [2:0] lane_reg_d [0:NUM_LANES-1];

    // Eight-entry read view so a 3-bit lane index never runs off the array;
    // lanes beyond NUM_LANES read as an empty code.
    logic [2:0] lane_rd [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane_rd
            if (gi < NUM_LANES) begin : g_used
                assign lane_rd[gi] = lane_reg_q[gi];
            end else begin : g_unused
                assign lane_rd[gi] = 3'd0;
            end
        end
    endgenerate

    logic       wrap;
    logic [5:0] next_off;
    logic [2:0] cur_val;
    logic [2:0] shift_val;
    logic [2:0] draw_val;
    logic       erase_skip;
    logic       draw_skip;

    assign wrap      = (offset_q == 6'(OFFSET_MAX));
    assign next_off  = wrap ? 6'd0 : offset_q + 6'd1;
    assign cur_val   = lane_rd[lane_q[2:0]];
    // On the wrapping frame the redraw already shows the post-shift contents,
    // even though the shift itself is only committed in FINISH.
    assign shift_val = (lane_q == 4'd0) ? new_row : lane_rd[lane_q[2:0] - 3'd1];
    assign draw_val  = wrap ? shift_val : cur_val;

`ifdef LANE_SKIP_EN
    assign erase_skip = (cur_val == 3'd0);
    assign draw_skip  = (draw_val == 3'd0);
`else
    assign erase_skip = 1'b0;
    assign draw_skip  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lane_q   <= 4'd0;
            offset_q <= 6'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_reg_q[i] <= 3'd0;
            end
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            offset_q <= offset_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_reg_q[i] <= lane_reg_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        offset_d    = offset_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_reg_d[i] = lane_reg_q[i];
        end
        eng_lane    = lane_q;
        eng_val     = cur_val;
        eng_offset  = offset_q;
        erase_go    = 1'b0;
        draw_go     = 1'b0;
        x_out       = 9'd0;
        y_out       = 8'd0;
        c_out       = 3'd0;
        plot        = 1'b0;
        busy        = (state_q != S_IDLE);
        frame_done  = 1'b0;
        row_advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_go) begin
                    lane_d  = 4'd0;
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                if (erase_skip) begin
                    state_d = S_ERASE_GAP;
                end else begin
                    erase_go = 1'b1;
                    plot     = !erase_done;
                    x_out    = erase_x;
                    y_out    = erase_y;
                    if (erase_done) begin
                        state_d = S_ERASE_GAP;
                    end
                end
            end
            S_ERASE_GAP: begin
                // Go low for a cycle so the engine sees a fresh start.
                state_d = S_DRAW;
            end
            S_DRAW: begin
                eng_val    = draw_val;
                eng_offset = next_off;
                if (draw_skip) begin
                    state_d = S_DRAW_GAP;
                end else begin
                    draw_go = 1'b1;
                    plot    = !draw_done;
                    x_out   = draw_x;
                    y_out   = draw_y;
                    c_out   = draw_c ? DRAW_COLOR : 3'b000;
                    if (draw_done) begin
                        state_d = S_DRAW_GAP;
                    end
                end
            end
            S_DRAW_GAP: begin
                if (lane_q == 4'(NUM_LANES - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    lane_d  = lane_q + 4'd1;
                    state_d = S_ERASE;
                end
            end
            S_FINISH: begin
                frame_done = 1'b1;
                offset_d   = next_off;
                if (wrap) begin
                    row_advance   = 1'b1;
                    lane_reg_d[0] = new_row;
                    for (int i = 1; i < NUM_LANES; i++) begin
                        lane_reg_d[i] = lane_reg_q[i-1];
                    end
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lane_frame_scheduler.sv
// Bench for lane_frame_scheduler: random engine lengths and new_row codes,
// every cycle compared against a schedule built from the frame rules.
module tb_lane_frame_scheduler;

    localparam int NL   = 4;
    localparam int OMAX = 39;
`ifdef LANE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_go;
    logic [2:0] new_row;
    logic [3:0] eng_lane;
    logic [2:0] eng_val;
    logic [5:0] eng_offset;
    logic       erase_go, erase_done;
    logic [8:0] erase_x;
    logic [7:0] erase_y;
    logic       draw_go, draw_done;
    logic [8:0] draw_x;
    logic [7:0] draw_y;
    logic       draw_c = 1'b0;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] c_out;
    logic       plot, busy, frame_done, row_advance;

    always #5 clk = ~clk;

    lane_frame_scheduler dut (
        .clk(clk), .reset(reset), .frame_go(frame_go), .new_row(new_row),
        .eng_lane(eng_lane), .eng_val(eng_val), .eng_offset(eng_offset),
        .erase_go(erase_go), .erase_done(erase_done),
        .erase_x(erase_x), .erase_y(erase_y),
        .draw_go(draw_go), .draw_done(draw_done),
        .draw_x(draw_x), .draw_y(draw_y), .draw_c(draw_c),
        .x_out(x_out), .y_out(y_out), .c_out(c_out), .plot(plot),
        .busy(busy), .frame_done(frame_done), .row_advance(row_advance)
    );

    // Engine models: busy length per lane, counted from go high, done inclusive.
    int e_len [NL];
    int d_len [NL];
    int ecnt = 0;
    int dcnt = 0;

    always @(posedge clk) begin
        ecnt   <= erase_go ? ecnt + 1 : 0;
        dcnt   <= draw_go ? dcnt + 1 : 0;
        draw_c <= 1'($urandom);
    end

    assign erase_done = erase_go && (eng_lane < 4'(NL)) && (ecnt == e_len[eng_lane[1:0]] - 1);
    assign draw_done  = draw_go && (eng_lane < 4'(NL)) && (dcnt == d_len[dcnt % 1 + eng_lane[1:0]] - 1);
    assign erase_x    = 9'(ecnt + 32 * int'(eng_lane));
    assign erase_y    = 8'(ecnt + 5);
    assign draw_x     = 9'(dcnt * 2 + 100);
    assign draw_y     = 8'(dcnt + 7 * int'(eng_lane));

    // Reference model: scroll offset and lane codes as plain integers.
    int m_off;
    int m_lane [NL];

    typedef struct {
        int kind;   // 0 erase, 1 erase gap, 2 draw, 3 draw gap, 4 finish
        int lane;
        bit last;
        bit skip;
    } rec_t;
    rec_t sched[$];
    int   exp_ev [NL];
    int   exp_dv [NL];

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic build_sched();
        rec_t r;
        int   n;
        bit   sk;
        sched.delete();
        for (int l = 0; l < NL; l++) begin
            exp_ev[l] = m_lane[l];
            if (m_off == OMAX) exp_dv[l] = (l == 0) ? int'(new_row) : m_lane[l-1];
            else               exp_dv[l] = m_lane[l];
            sk = SKIP && (exp_ev[l] == 0);
            n  = sk ? 1 : e_len[l];
            for (int k = 0; k < n; k++) begin
                r = '{0, l, (k == n - 1), sk};
                sched.push_back(r);
            end
            r = '{1, l, 1'b1, 1'b0};
            sched.push_back(r);
            sk = SKIP && (exp_dv[l] == 0);
            n  = sk ? 1 : d_len[l];
            for (int k = 0; k < n; k++) begin
                r = '{2, l, (k == n - 1), sk};
                sched.push_back(r);
            end
            r = '{3, l, 1'b1, 1'b0};
            sched.push_back(r);
        end
        r = '{4, NL - 1, 1'b1, 1'b0};
        sched.push_back(r);
    endtask

    // Runs one frame from an idle negedge; glitch>0 re-pulses frame_go mid-frame.
    task automatic run_frame(input int glitch);
        rec_t r;
        logic e_go, d_go, p_on, fd, ra;
        int   len;
        int   wrapped;
        build_sched();
        len      = sched.size();
        wrapped  = (m_off == OMAX);
        frame_go = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            frame_go = (glitch > 0 && c == glitch) ? 1'b1 : 1'b0;
            r    = sched[c];
            e_go = (r.kind == 0) && !r.skip;
            d_go = (r.kind == 2) && !r.skip;
            p_on = (e_go || d_go) && !r.last;
            fd   = (r.kind == 4);
            ra   = fd && (wrapped != 0);
            check("ctl", {22'd0, erase_go, draw_go, plot, busy, frame_done, row_advance, eng_lane},
                         {22'd0, e_go, d_go, p_on, 1'b1, fd, ra, 4'(r.lane)});
            if (r.kind == 0)
                check("erase_eng", {23'd0, eng_val, eng_offset},
                                   {23'd0, 3'(exp_ev[r.lane]), 6'(m_off)});
            if (r.kind == 2)
                check("draw_eng", {23'd0, eng_val, eng_offset},
                                  {23'd0, 3'(exp_dv[r.lane]), 6'((m_off + 1) % (OMAX + 1))});
            if (p_on && r.kind == 0)
                check("erase_pix", {12'd0, x_out, y_out, c_out}, {12'd0, erase_x, erase_y, 3'b000});
            if (p_on && r.kind == 2)
                check("draw_pix", {12'd0, x_out, y_out, c_out},
                                  {12'd0, draw_x, draw_y, draw_c ? 3'b111 : 3'b000});
            if (r.kind == 1 || r.kind == 3 || r.kind == 4)
                check("gap_pix", {11'd0, x_out, y_out, c_out, plot}, 32'd0);
        end
        @(negedge clk);
        frame_go = 1'b0;
        check("idle_after", {30'd0, busy, frame_done}, 32'd0);
        if (wrapped != 0) begin
            for (int l = NL - 1; l > 0; l--) m_lane[l] = m_lane[l-1];
            m_lane[0] = int'(new_row);
        end
        m_off = (m_off + 1) % (OMAX + 1);
        frame_no++;
        $display("frame %0d len=%0d new_row=%0d wrapped=%0d next_off=%0d", frame_no, len, new_row, wrapped, m_off);
    endtask

    task automatic set_lens(input int lo, input int hi);
        for (int l = 0; l < NL; l++) begin
            e_len[l] = int'($urandom_range(hi, lo));
            d_len[l] = int'($urandom_range(hi, lo));
        end
    endtask

    initial begin
        reset    = 1'b1;
        frame_go = 1'b0;
        new_row  = 3'd0;
        m_off    = 0;
        for (int l = 0; l < NL; l++) m_lane[l] = 0;
        set_lens(1, 1);
        repeat (3) @(negedge clk);
        check("reset_ctl", {22'd0, erase_go, draw_go, plot, busy, frame_done, row_advance, eng_lane}, 32'd0);
        check("reset_data", {5'd0, eng_val, eng_offset, x_out, y_out, c_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // All lanes empty, single-cycle engines.
        run_frame(0);

        // Random frames through the first offset wrap and beyond.
        for (int f = 1; f <= 44; f++) begin
            if (f == 1)       set_lens(21, 21);
            else if (f == 42) set_lens(1, 1);
            else              set_lens(1, 5);
            new_row = (f == 39) ? 3'd3 : 3'($urandom_range(7, 1));
            run_frame((f == 5) ? 6 : 0);
        end

        // Reset in the middle of a draw phase.
        set_lens(4, 4);
        frame_go = 1'b1;
        for (int c = 0; c < 200 && !draw_go; c++) begin
            @(negedge clk);
            frame_go = 1'b0;
        end
        check("reach_draw", {31'd0, draw_go}, 32'd1);
        #2 reset = 1'b1;
        #1 check("abort", {28'd0, erase_go, draw_go, plot, busy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_done_rst", {31'd0, frame_done}, 32'd0);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no_done_idle", {30'd0, frame_done, busy}, 32'd0);
        end
        m_off = 0;
        for (int l = 0; l < NL; l++) m_lane[l] = 0;
        set_lens(1, 4);
        run_frame(0);
        set_lens(2, 6);
        run_frame(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
